// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, op legality check and FSM encoding shared by alu_req_sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
    endfunction

endpackage

// File: rtl/alu_req_sequencer_rr_arb2.sv
// rr_arb2: two-way round-robin grant; a tie goes to the requester that did not win last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb
        gnt = !en ? 2'b00 : (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;

endmodule

// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: shares one registered ALU between two requesters, one operation
// in flight at a time, returning tagged results over a valid/ready response channel.
module alu_req_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic [3:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    input  logic [3:0]        req1_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              resp_cout,
    output logic              resp_overflow,
    output logic              resp_err,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    output logic              busy
);

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic              last_grant_q;
    logic              resp_valid_q, resp_id_q, resp_zero_q, resp_cout_q, resp_overflow_q, resp_err_q;
    logic [DATA_W-1:0] resp_result_q, alu_src1_q, alu_src2_q;
    logic [3:0]        alu_ctrl_q;
    logic [1:0]        gnt;
    logic              sel;
    logic [3:0]        op;
    logic [DATA_W-1:0] src1, src2;

    rr_arb2 u_arb (
        .req       ({req1_valid, req0_valid}),
        .last_grant(last_grant_q),
        .en        (state_q == IDLE),
        .gnt       (gnt)
    );

    assign sel  = gnt[1];
    assign op   = sel ? req1_op : req0_op;
    assign src1 = sel ? req1_src1 : req0_src1;
    assign src2 = sel ? req1_src2 : req0_src2;

    assign req0_ready    = gnt[0];
    assign req1_ready    = gnt[1];
    assign busy          = state_q != IDLE;
    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_result   = resp_result_q;
    assign resp_zero     = resp_zero_q;
    assign resp_cout     = resp_cout_q;
    assign resp_overflow = resp_overflow_q;
    assign resp_err      = resp_err_q;
    assign alu_src1      = alu_src1_q;
    assign alu_src2      = alu_src2_q;
    assign alu_ctrl      = alu_ctrl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            last_grant_q    <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= 1'b0;
            resp_result_q   <= '0;
            resp_zero_q     <= 1'b0;
            resp_cout_q     <= 1'b0;
            resp_overflow_q <= 1'b0;
            resp_err_q      <= 1'b0;
            alu_src1_q      <= '0;
            alu_src2_q      <= '0;
            alu_ctrl_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (|gnt) begin
                    last_grant_q <= sel;
                    resp_id_q    <= sel;
                    if (op_legal(op)) begin
                        alu_src1_q <= src1;
                        alu_src2_q <= src2;
                        alu_ctrl_q <= op;
                        cnt_q      <= 3'(ALU_LAT);
                        state_q    <= EXEC;
                    end else begin
                        // Illegal ops never reach the ALU; the ALU inputs keep the last legal op.
                        resp_result_q   <= '0;
                        resp_zero_q     <= 1'b0;
                        resp_cout_q     <= 1'b0;
                        resp_overflow_q <= 1'b0;
                        resp_err_q      <= 1'b1;
                        resp_valid_q    <= 1'b1;
                        state_q         <= RESP;
                    end
                end
                EXEC: if (cnt_q != 3'd0) begin
                    cnt_q <= cnt_q - 3'd1;
                end else begin
                    resp_result_q   <= alu_result;
                    resp_zero_q     <= alu_zero;
                    resp_cout_q     <= alu_cout;
                    resp_overflow_q <= alu_overflow;
                    resp_err_q      <= 1'b0;
                    resp_valid_q    <= 1'b1;
                    state_q         <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
